// File: rtl/psum_drain.sv
// rtl/psum_drain.sv - queues psum vectors and drains them one column per beat
// Optional build macro: PSUM_DRAIN_RELU_EN clamps negative columns to zero.
module psum_drain #(
    parameter int col     = 8,
    parameter int bw      = 8,
    parameter int bw_psum = 2 * bw + 3,
    parameter int depth   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [col*bw_psum-1:0]   psum_in,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [bw_psum-1:0]       out_data,
    output logic [$clog2(col)-1:0]   out_col,
    output logic                     out_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [15:0]              frame_cnt
);
    localparam int cw = $clog2(col);
    localparam int aw = $clog2(depth);
    localparam logic [0:0] st_idle  = 1'b0;
    localparam logic [0:0] st_shift = 1'b1;
    localparam logic [aw:0] full_lvl = (aw + 1)'(depth);
    localparam logic [cw-1:0] last_idx = cw'(col - 1);

    logic [col*bw_psum-1:0] mem_q [depth];
    logic [aw-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [aw:0]            count_q, count_d;
    logic [0:0]             state_q, state_d;
    logic [cw-1:0]          col_q, col_d;
    logic [col*bw_psum-1:0] hold_q, hold_d;
    logic [15:0]            frame_q, frame_d;

    logic full, empty, push, pop, hs, last_col, fin;
    logic [bw_psum-1:0] sel_col;

    always_comb begin
        full     = (count_q == full_lvl);
        empty    = (count_q == '0);
        push     = in_valid && !full;
        last_col = (col_q == last_idx);
        hs       = (state_q == st_shift) && out_ready;
        fin      = hs && last_col;
        // A finishing beat refills straight from the FIFO so frames stream without a bubble.
        pop      = !empty && ((state_q == st_idle) || fin);

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + {{aw{1'b0}}, push} - {{aw{1'b0}}, pop};

        state_d = state_q;
        col_d   = col_q;
        hold_d  = hold_q;
        frame_d = frame_q;
        if (fin) begin
            frame_d = frame_q + 16'd1;
            state_d = st_idle;
            col_d   = '0;
        end else if (hs) begin
            col_d = col_q + 1'b1;
        end
        if (pop) begin
            hold_d  = mem_q[rd_ptr_q];
            col_d   = '0;
            state_d = st_shift;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= psum_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= st_idle;
            col_q    <= '0;
            hold_q   <= '0;
            frame_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            col_q    <= col_d;
            hold_q   <= hold_d;
            frame_q  <= frame_d;
        end
    end

    always_comb begin
        sel_col = hold_q[int'(col_q)*bw_psum +: bw_psum];
`ifdef PSUM_DRAIN_RELU_EN
        if (sel_col[bw_psum-1]) begin
            sel_col = '0;
        end
`endif
    end

    assign in_ready  = !full;
    assign out_valid = (state_q == st_shift);
    assign out_data  = out_valid ? sel_col : '0;
    assign out_col   = col_q;
    assign out_last  = last_col && out_valid;
    assign frame_cnt = frame_q;

endmodule
